// File: rtl/key_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// key_scan_ctrl_if
// Bundles the keyboard scan signals between the SKCTL/matrix side (master)
// and the scan sequencer (slave).
//   scanStb    : one-cycle scan-step strobe, one address per strobe
//   kbdScanEn  : SKCTL keyboard-scan enable
//   debounceEn : SKCTL debounce enable
//   iKR1       : key return, 1 = key at current address pressed
//   iKR2       : shift return, 1 = shift pressed
//   kbdAddr    : current scan address (K0-K5)
//   kbcode     : latched code, MSB = shift
//   keyDown    : 1 while a debounced key is held
//   keyIrq     : one-clk pulse when kbcode is loaded
// ---------------------------------------------------------------------------
interface key_scan_ctrl_if #(
    parameter int SCAN_BITS = 6
);
    logic                 scanStb;
    logic                 kbdScanEn;
    logic                 debounceEn;
    logic                 iKR1;
    logic                 iKR2;
    logic [SCAN_BITS-1:0] kbdAddr;
    logic [SCAN_BITS:0]   kbcode;
    logic                 keyDown;
    logic                 keyIrq;

    modport master (
        output scanStb, kbdScanEn, debounceEn, iKR1, iKR2,
        input  kbdAddr, kbcode, keyDown, keyIrq
    );

    modport slave (
        input  scanStb, kbdScanEn, debounceEn, iKR1, iKR2,
        output kbdAddr, kbcode, keyDown, keyIrq
    );
endinterface

// File: rtl/key_scan_ctrl.sv
// ---------------------------------------------------------------------------
// key_scan_ctrl
// Keyboard scan sequencer: steps the key-matrix scan address, runs the
// two-bit debounce state machine against the compare latch, loads KBCODE
// and raises the keyboard interrupt pulse and key-down status.
//   clk    : system clock
//   nReset : asynchronous active-low reset
//   kbd    : key_scan_ctrl_if slave (strobe/enables/returns in,
//            address/code/status/irq out)
// ---------------------------------------------------------------------------
module key_scan_ctrl #(
    parameter int SCAN_BITS = 6
) (
    input  logic            clk,
    input  logic            nReset,
    key_scan_ctrl_if.slave  kbd
);

    // Encoding matches the SKSTAT-visible debounce state bits.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CAND = 2'b01,
        HELD = 2'b11,
        REL  = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [SCAN_BITS-1:0] addr_q,  addr_d;
    logic [SCAN_BITS-1:0] comp_q,  comp_d;
    logic [SCAN_BITS:0]   code_q,  code_d;
    logic                 irq_q,   irq_d;

    logic key;
    logic match;

    // key refers to the address being scanned this strobe (pre-increment).
    // With debounce off every address counts as a match.
    assign key   = kbd.iKR1;
    assign match = (addr_q == comp_q) || !kbd.debounceEn;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        comp_d  = comp_q;
        code_d  = code_q;
        irq_d   = 1'b0;

        if (!kbd.kbdScanEn) begin
            // Disabled scanning parks the sequencer; latched code and
            // compare address are kept.
            addr_d  = '0;
            state_d = IDLE;
        end else if (kbd.scanStb) begin
            addr_d = addr_q + SCAN_BITS'(1);
            unique case (state_q)
                IDLE: begin
                    if (key) begin
                        comp_d = addr_q;
                        if (kbd.debounceEn) begin
                            state_d = CAND;
                        end else begin
                            code_d  = {kbd.iKR2, addr_q};
                            irq_d   = 1'b1;
                            state_d = HELD;
                        end
                    end
                end
                CAND: begin
                    if (match) begin
                        if (key) begin
                            code_d  = {kbd.iKR2, addr_q};
                            irq_d   = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                HELD: begin
                    if (match && !key) begin
                        state_d = REL;
                    end
                end
                REL: begin
                    // A returning key during release is a bounce, not a
                    // new press: no reload and no interrupt.
                    if (match) begin
                        state_d = key ? HELD : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            comp_q  <= '0;
            code_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            comp_q  <= comp_d;
            code_q  <= code_d;
            irq_q   <= irq_d;
        end
    end

    assign kbd.kbdAddr = addr_q;
    assign kbd.kbcode  = code_q;
    assign kbd.keyDown = state_q[1];  // HELD (11) and REL (10)
    assign kbd.keyIrq  = irq_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
module tb_key_scan_ctrl;

    logic clk;
    logic nReset;

    key_scan_ctrl_if #(.SCAN_BITS(6)) kbd ();

    key_scan_ctrl #(.SCAN_BITS(6)) dut (
        .clk    (clk),
        .nReset (nReset),
        .kbd    (kbd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    logic [5:0] m_addr;

    typedef struct {
        int         n;
        bit         key_en;
        logic [5:0] key_addr;
        bit         kr2;
        bit         deb;
        bit         en;
        logic [5:0] e_addr;
        logic [6:0] e_code;
        bit         e_kd;
        int         e_irq;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs n strobes with a matrix model that reports a key only at key_addr,
    // then two quiet cycles; returns how many cycles keyIrq was seen high.
    task automatic run_phase(input int n, input bit key_en, input logic [5:0] key_addr,
                             input bit kr2, input bit deb, input bit en, output int irq_cnt);
        irq_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (kbd.keyIrq === 1'b1) irq_cnt++;
            kbd.scanStb    = 1'b1;
            kbd.kbdScanEn  = en;
            kbd.debounceEn = deb;
            kbd.iKR1       = key_en && (m_addr == key_addr);
            kbd.iKR2       = kr2;
            m_addr         = en ? m_addr + 6'd1 : 6'd0;
        end
        @(negedge clk);
        if (kbd.keyIrq === 1'b1) irq_cnt++;
        kbd.scanStb   = 1'b0;
        kbd.iKR1      = 1'b0;
        kbd.iKR2      = 1'b0;
        kbd.kbdScanEn = 1'b1;
        @(negedge clk);
        if (kbd.keyIrq === 1'b1) irq_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int irq_cnt;
        string nm;

        //            n   ken kaddr  kr2 deb en  e_addr e_code  kd irq
        tbl[0]  = '{64, 1, 6'h15, 0, 1, 1, 6'd0,  7'h00, 0, 0}; // first hit -> CAND
        tbl[1]  = '{64, 1, 6'h15, 0, 1, 1, 6'd0,  7'h15, 1, 1}; // second hit -> HELD
        tbl[2]  = '{64, 1, 6'h15, 0, 1, 1, 6'd0,  7'h15, 1, 0}; // still held
        tbl[3]  = '{64, 0, 6'h00, 0, 1, 1, 6'd0,  7'h15, 1, 0}; // first miss -> REL
        tbl[4]  = '{64, 0, 6'h00, 0, 1, 1, 6'd0,  7'h15, 0, 0}; // second miss -> IDLE
        tbl[5]  = '{64, 1, 6'h0C, 0, 1, 1, 6'd0,  7'h15, 0, 0}; // bounce: CAND
        tbl[6]  = '{64, 0, 6'h00, 0, 1, 1, 6'd0,  7'h15, 0, 0}; // bounce: gone -> IDLE
        tbl[7]  = '{64, 1, 6'h0C, 0, 1, 1, 6'd0,  7'h15, 0, 0}; // IDLE again: only CAND
        tbl[8]  = '{64, 0, 6'h00, 0, 1, 1, 6'd0,  7'h15, 0, 0}; // back to IDLE
        tbl[9]  = '{64, 1, 6'h15, 0, 1, 1, 6'd0,  7'h15, 0, 0}; // CAND
        tbl[10] = '{64, 1, 6'h15, 1, 1, 1, 6'd0,  7'h55, 1, 1}; // HELD with shift
        tbl[11] = '{64, 0, 6'h00, 0, 1, 1, 6'd0,  7'h55, 1, 0}; // REL
        tbl[12] = '{64, 1, 6'h15, 0, 1, 1, 6'd0,  7'h55, 1, 0}; // REL -> HELD, no reload
        tbl[13] = '{64, 0, 6'h00, 0, 1, 1, 6'd0,  7'h55, 1, 0}; // REL
        tbl[14] = '{64, 0, 6'h00, 0, 1, 1, 6'd0,  7'h55, 0, 0}; // IDLE
        tbl[15] = '{43, 1, 6'h2A, 1, 0, 1, 6'd43, 7'h6A, 1, 1}; // debounce off, immediate
        tbl[16] = '{21, 0, 6'h00, 0, 0, 1, 6'd0,  7'h6A, 0, 0}; // release, no debounce
        tbl[17] = '{30, 1, 6'h15, 0, 1, 1, 6'd30, 7'h6A, 0, 0}; // CAND at 0x15
        tbl[18] = '{5,  1, 6'h00, 0, 1, 0, 6'd0,  7'h6A, 0, 0}; // scan disabled
        tbl[19] = '{64, 1, 6'h15, 0, 1, 1, 6'd0,  7'h6A, 0, 0}; // restarted from IDLE

        n_checks = 0;
        n_errors = 0;
        m_addr   = 6'd0;

        nReset         = 1'b0;
        kbd.scanStb    = 1'b0;
        kbd.kbdScanEn  = 1'b1;
        kbd.debounceEn = 1'b1;
        kbd.iKR1       = 1'b0;
        kbd.iKR2       = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_addr",  32'(kbd.kbdAddr), 32'd0);
        chk("reset_code",  32'(kbd.kbcode),  32'd0);
        chk("reset_kd",    32'(kbd.keyDown), 32'd0);
        chk("reset_irq",   32'(kbd.keyIrq),  32'd0);
        nReset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_phase(tbl[i].n, tbl[i].key_en, tbl[i].key_addr, tbl[i].kr2,
                      tbl[i].deb, tbl[i].en, irq_cnt);
            nm = $sformatf("vec%0d_addr", i);
            chk(nm, 32'(kbd.kbdAddr), 32'(tbl[i].e_addr));
            nm = $sformatf("vec%0d_code", i);
            chk(nm, 32'(kbd.kbcode), 32'(tbl[i].e_code));
            nm = $sformatf("vec%0d_keydown", i);
            chk(nm, 32'(kbd.keyDown), 32'(tbl[i].e_kd));
            nm = $sformatf("vec%0d_irqcount", i);
            chk(nm, 32'(irq_cnt), 32'(tbl[i].e_irq));
        end

        // Wrap: 63 strobes reach address 63, the next one returns to 0.
        run_phase(63, 0, 6'h00, 0, 1, 1, irq_cnt);
        chk("wrap_addr63", 32'(kbd.kbdAddr), 32'd63);
        run_phase(1, 0, 6'h00, 0, 1, 1, irq_cnt);
        chk("wrap_addr0", 32'(kbd.kbdAddr), 32'd0);
        chk("wrap_keydown", 32'(kbd.keyDown), 32'd0);

        // Cycle-level: debounce off, key at address 0 with shift.
        @(negedge clk);
        kbd.scanStb    = 1'b1;
        kbd.debounceEn = 1'b0;
        kbd.iKR1       = 1'b1;
        kbd.iKR2       = 1'b1;
        @(negedge clk);
        kbd.scanStb = 1'b0;
        kbd.iKR1    = 1'b0;
        kbd.iKR2    = 1'b0;
        chk("cyc_irq_high", 32'(kbd.keyIrq),  32'd1);
        chk("cyc_keydown",  32'(kbd.keyDown), 32'd1);
        chk("cyc_code",     32'(kbd.kbcode),  32'h40);
        chk("cyc_addr",     32'(kbd.kbdAddr), 32'd1);
        // Asynchronous reset while the IRQ pulse is pending.
        #2;
        nReset = 1'b0;
        #1;
        chk("abort_irq",  32'(kbd.keyIrq),  32'd0);
        chk("abort_kd",   32'(kbd.keyDown), 32'd0);
        chk("abort_code", 32'(kbd.kbcode),  32'd0);
        chk("abort_addr", 32'(kbd.kbdAddr), 32'd0);
        nReset = 1'b1;
        m_addr = 6'd0;
        kbd.debounceEn = 1'b1;

        // Reset out of HELD with kbcode 0x15.
        run_phase(64, 1, 6'h15, 0, 1, 1, irq_cnt);
        run_phase(64, 1, 6'h15, 0, 1, 1, irq_cnt);
        chk("held_code", 32'(kbd.kbcode),  32'h15);
        chk("held_kd",   32'(kbd.keyDown), 32'd1);
        @(negedge clk);
        #2;
        nReset = 1'b0;
        #1;
        chk("rst_held_code", 32'(kbd.kbcode),  32'd0);
        chk("rst_held_kd",   32'(kbd.keyDown), 32'd0);
        chk("rst_held_irq",  32'(kbd.keyIrq),  32'd0);
        chk("rst_held_addr", 32'(kbd.kbdAddr), 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_scan_ctrl.md
# key_scan_ctrl

Keyboard scan sequencer for the POKEY keyboard subsystem. It drives the 6-bit key-matrix scan address, runs the 2-bit debounce state machine, holds the compare latch, and loads the KBCODE register. It also raises the keyboard-interrupt pulse and the key-down status bit. It sits between the SKCTL register bits, the external matrix returns (KR1/KR2) and the CPU-visible KBCODE/SKSTAT/IRQST logic.

## Interface

Parameters:
- SCAN_BITS, 6: width of scan address and compare latch

Ports:
- clk  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- scanStb  in  1  one-cycle scan-step strobe (one scan address per strobe)
- kbdScanEn  in  1  SKCTL keyboard-scan enable
- debounceEn  in  1  SKCTL debounce enable
- iKR1  in  1  key return, already inverted: 1 = key at current address pressed
- iKR2  in  1  shift return, already inverted: 1 = shift pressed
- kbdAddr  out  SCAN_BITS  current scan address (K0-K5)
- kbcode  out  SCAN_BITS+1  latched code; bit SCAN_BITS = shift
- keyDown  out  1  1 while a debounced key is held
- keyIrq  out  1  one-clk pulse when kbcode is loaded

## Operation

- All state updates occur only on a clk edge with scanStb=1 and kbdScanEn=1. Otherwise registers hold, except as noted for kbdScanEn=0.
- Scan counter: kbdAddr increments by 1 per strobe and wraps 63 -> 0 (modulo 2^SCAN_BITS).
- Definitions:
  - key = iKR1, sampled for the current kbdAddr, i.e. the value before the increment.
  - match = (kbdAddr == compReg), or 1 when debounceEn=0.
- States: IDLE(00), CAND(01), HELD(11), REL(10). On each strobe:
  - IDLE:
    - key=1 and debounceEn=1: compReg<=kbdAddr, go to CAND.
    - key=1 and debounceEn=0: compReg<=kbdAddr, load kbcode, pulse keyIrq, go to HELD.
    - key=0: stay.
  - CAND (only when match):
    - key=1: load kbcode, pulse keyIrq, go to HELD.
    - key=0: go to IDLE.
    - No match: stay.
  - HELD (only when match):
    - key=0: go to REL.
    - key=1: stay.
    - No match: stay.
  - REL (only when match):
    - key=0: go to IDLE.
    - key=1: go to HELD, with no reload and no IRQ.
    - No match: stay.
- kbcode load: kbcode <= {iKR2, kbdAddr}, both sampled on the loading strobe.
- keyDown = 1 in HELD or REL; 0 in IDLE or CAND.
- kbdScanEn=0 (synchronous, every clk):
  - kbdAddr<=0 and state<=IDLE.
  - keyIrq is forced to 0.
  - compReg and kbcode hold.
- scanStb while kbdScanEn=0 is ignored.

## Timing

- Reset (nReset=0, asynchronous): kbdAddr=0, state=IDLE, compReg=0, kbcode=0, keyDown=0, keyIrq=0. Release is synchronous to clk, and the first strobe takes effect no earlier than the first edge after release.
- Latency:
  - kbdAddr, kbcode and keyDown are registered and change on the same edge as the qualifying strobe.
  - keyIrq is high for exactly the clk cycle following that edge.
- Debounced press: an IRQ needs two hits at the same address one full scan apart, i.e. 2^SCAN_BITS strobes.
- Debounced release: needs two consecutive misses at compReg.
- Reset asserted mid-operation aborts immediately, with no pending IRQ.
- Back-to-back strobes, one per clk, are legal.

## Test plan

- Reset in HELD with kbcode=0x15 -> all outputs 0 asynchronously.
- Debounced press:
  - Stimulus: debounceEn=1, iKR1=1 only at addr 0x15, iKR2=0.
  - First pass -> CAND with keyIrq=0.
  - Second pass -> kbcode=0x15, keyIrq=1 for one clk, keyDown=1.
- Bounce:
  - Stimulus: key present at 0x15 on the first pass, absent on the second.
  - Response: return to IDLE, keyIrq never asserted, kbcode unchanged.
- Release:
  - From HELD at 0x15, drive iKR1=0.
  - First pass -> REL with keyDown=1.
  - Second pass -> IDLE with keyDown=0.
  - Repeat with key=1 on the second pass -> back to HELD with no IRQ.
- Debounce off:
  - Stimulus: debounceEn=0, key at 0x2A, iKR2=1.
  - Response on the first hit: kbcode=0x6A, keyIrq pulse, keyDown=1.
- Scan disable and wrap:
  - Drop kbdScanEn while in CAND -> kbdAddr=0, state IDLE, no IRQ, kbcode held.
  - Then 64 strobes from 0 -> kbdAddr wraps 63 -> 0.
